fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 6 +
 rtl/fetch_unit_jump_lut.sv | 21 ++
 rtl/fetch_unit.sv | 56 +++++
 tb/tb_fetch_unit.sv | 117 +++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths and FSM encoding for the fetch unit.
package fetch_unit_pkg;
    localparam int PC_W = 10;
    localparam int LUT_W = 5;
    typedef enum logic [1:0] {IDLE, RUN, HALTED} fsm_state_t;
endpackage

// File: rtl/fetch_unit_jump_lut.sv
// jump_lut: constant table mapping a jump index to an absolute PC.
module jump_lut #(
    parameter int PC_W = fetch_unit_pkg::PC_W,
    parameter int LUT_W = fetch_unit_pkg::LUT_W
) (
    input  logic [LUT_W-1:0] TargetIdx,
    output logic [PC_W-1:0]  Target
);
    always_comb begin
        case (TargetIdx)
            LUT_W'(0):  Target = PC_W'(0);
            LUT_W'(1):  Target = PC_W'(16);
            LUT_W'(2):  Target = PC_W'(100);
            LUT_W'(3):  Target = PC_W'(200);
            LUT_W'(4):  Target = PC_W'(300);
            LUT_W'(5):  Target = PC_W'(512);
            LUT_W'(31): Target = PC_W'(1023);
            default:    Target = '0;
        endcase
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter sequencer with IDLE/RUN/HALTED control,
// table-driven jumps and a saturating retired-instruction counter.
module fetch_unit #(
    parameter int PC_W = fetch_unit_pkg::PC_W,
    parameter int LUT_W = fetch_unit_pkg::LUT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             HaltIn,
    input  logic             JumpEn,
    input  logic             BranchEn,
    input  logic             ZeroIn,
    input  logic [LUT_W-1:0] TargetIdx,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Done,
    output logic [15:0]      InstrCount
);
    import fetch_unit_pkg::*;

    fsm_state_t state;
    logic [PC_W-1:0] target;
    logic take;

    jump_lut #(.PC_W(PC_W), .LUT_W(LUT_W)) u_jump_lut (
        .TargetIdx(TargetIdx),
        .Target(target)
    );

    // a branch is taken when the ALU compare is nonzero; a jump overrides it
    assign take = JumpEn | (BranchEn & ~ZeroIn);
    assign Running = state == RUN;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            PC <= '0;
            Done <= 1'b0;
            InstrCount <= '0;
        end else if (Start) begin
            state <= RUN;
            PC <= '0;
            Done <= 1'b0;
            InstrCount <= '0;
        end else if (state == RUN) begin
            InstrCount <= &InstrCount ? InstrCount : InstrCount + 16'd1;
            if (HaltIn) begin
                state <= HALTED;
                Done <= 1'b1;
            end else begin
                PC <= take ? target : PC + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus reset corner sequences.
module tb_fetch_unit;
    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic Start = 1'b0;
    logic HaltIn = 1'b0;
    logic JumpEn = 1'b0;
    logic BranchEn = 1'b0;
    logic ZeroIn = 1'b0;
    logic [4:0] TargetIdx = '0;
    logic [9:0] PC;
    logic Running;
    logic Done;
    logic [15:0] InstrCount;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic start, halt, jump, branch, zero;
        logic [4:0] idx;
        int pc;
        logic run, done;
        int cnt;
    } vec_t;

    vec_t vq[$];

    fetch_unit dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .HaltIn(HaltIn),
        .JumpEn(JumpEn), .BranchEn(BranchEn), .ZeroIn(ZeroIn),
        .TargetIdx(TargetIdx), .PC(PC), .Running(Running), .Done(Done),
        .InstrCount(InstrCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int pc, input int run, input int done, input int cnt);
        chk({tag, " pc"}, int'(PC), pc);
        chk({tag, " running"}, int'(Running), run);
        chk({tag, " done"}, int'(Done), done);
        chk({tag, " count"}, int'(InstrCount), cnt);
    endtask

    function automatic void add(input logic st, input logic h, input logic j, input logic b,
                                input logic z, input int idx, input int pc, input logic run,
                                input logic done, input int cnt);
        vec_t v;
        v.start = st; v.halt = h; v.jump = j; v.branch = b; v.zero = z;
        v.idx = 5'(idx); v.pc = pc; v.run = run; v.done = done; v.cnt = cnt;
        vq.push_back(v);
    endfunction

    task automatic drive(input logic st, input logic h, input logic j, input logic b,
                         input logic z, input int idx);
        Start = st; HaltIn = h; JumpEn = j; BranchEn = b; ZeroIn = z; TargetIdx = 5'(idx);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 7; i++) add(0, 0, 0, 0, 0, 0, i, 1, 0, i);
        add(0, 0, 0, 1, 0, 2, 100, 1, 0, 8);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 7; i++) add(0, 0, 0, 0, 0, 0, i, 1, 0, i);
        add(0, 0, 0, 1, 1, 2, 8, 1, 0, 8);
        add(0, 0, 1, 1, 1, 1, 16, 1, 0, 9);
        add(0, 0, 1, 0, 0, 31, 1023, 1, 0, 10);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 11);
        add(0, 0, 1, 0, 0, 1, 16, 1, 0, 12);
        for (int i = 1; i <= 4; i++) add(0, 0, 0, 0, 1, 2, 16 + i, 1, 0, 12 + i);
        add(0, 1, 0, 0, 0, 0, 20, 0, 1, 17);
        for (int i = 0; i < 10; i++) add(0, i % 3 == 2, i % 3 == 0, i % 3 == 1, 0, 2, 20, 0, 1, 17);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        Reset = 1'b1;
        #1;
        chk_all("reset async", 0, 0, 0, 0);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        drive(0, 0, 1, 1, 0, 2);
        drive(0, 0, 0, 0, 0, 0);
        chk_all("idle hold", 0, 0, 0, 0);

        foreach (vq[k]) begin
            drive(vq[k].start, vq[k].halt, vq[k].jump, vq[k].branch, vq[k].zero, vq[k].idx);
            chk_all($sformatf("vec%0d", k), vq[k].pc, vq[k].run, vq[k].done, vq[k].cnt);
        end

        drive(0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 34; i++) drive(0, 0, 0, 0, 0, 0);
        chk_all("pre-reset", 50, 1, 0, 35);
        #2 Reset = 1'b1;
        #1;
        chk_all("mid-run reset", 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        chk_all("reset beats start", 0, 0, 0, 0);
        Reset = 1'b0;
        drive(1, 0, 0, 0, 0, 0);
        chk_all("start after reset", 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk_all("run after reset", 1, 1, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
